// File: rtl/switch_tx_receiver.sv
// Tx-port cell terminator: checks dest/length/checksum of byte-wide cells, buffers
// payload speculatively and releases only committed (good) cells downstream.
module switch_tx_receiver #(
  parameter logic [7:0] PORT_ID     = 8'd0,
  parameter int         DEPTH       = 64,
  parameter int         MAX_PAYLOAD = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0] MAXP = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, HDR_LEN, PAYLOAD, CSUM, DISCARD} state_t;

  state_t      state, state_n;
  logic [AW:0] wr_ptr, wr_ptr_n, rd_ptr, commit_ptr, commit_ptr_n;
  logic [7:0]  rem, rem_n, csum, csum_n;
  logic        we, good_inc, sop_flag, acc, rd_en;
  logic [1:0]  drop_inc;
  logic [8:0]  mem [DEPTH];
  logic [16:0] drop_sum;

  assign in_ready  = (wr_ptr - rd_ptr) != FULL;
  assign acc       = in_valid & in_ready;
  assign out_valid = rd_ptr != commit_ptr;
  assign rd_en     = out_valid & out_ready;
  assign {out_eop, out_data} = mem[rd_ptr[AW-1:0]];
  assign out_sop   = sop_flag;
  assign drop_sum  = {1'b0, drop_cnt} + 17'(drop_inc);

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    rem_n        = rem;
    csum_n       = csum;
    we           = 1'b0;
    good_inc     = 1'b0;
    drop_inc     = 2'd0;
    if (acc) begin
      // a sop mid-cell abandons the current cell, then starts a new one
      if (in_sop && state != IDLE) begin
        drop_inc = 2'd1;
        wr_ptr_n = commit_ptr;
      end
      if (in_sop) begin
        csum_n = in_data;
        if (in_eop) begin
          drop_inc = drop_inc + 2'd1;
          wr_ptr_n = commit_ptr;
          state_n  = IDLE;
        end else begin
          state_n = (in_data == PORT_ID) ? HDR_LEN : DISCARD;
        end
      end else begin
        unique case (state)
          IDLE: ;
          HDR_LEN: begin
            if (in_eop) begin
              drop_inc = 2'd1;
              wr_ptr_n = commit_ptr;
              state_n  = IDLE;
            end else if (in_data == 8'd0 || in_data > MAXP) begin
              state_n = DISCARD;
            end else begin
              rem_n   = in_data;
              csum_n  = csum ^ in_data;
              state_n = PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (in_eop) begin
              drop_inc = 2'd1;
              wr_ptr_n = commit_ptr;
              state_n  = IDLE;
            end else begin
              we       = 1'b1;
              wr_ptr_n = wr_ptr + 1'b1;
              rem_n    = rem - 8'd1;
              csum_n   = csum ^ in_data;
              if (rem == 8'd1) state_n = CSUM;
            end
          end
          CSUM: begin
            if (in_eop) begin
              if (in_data == csum) begin
                commit_ptr_n = wr_ptr;
                good_inc     = 1'b1;
              end else begin
                drop_inc = 2'd1;
                wr_ptr_n = commit_ptr;
              end
              state_n = IDLE;
            end else begin
              state_n = DISCARD;
            end
          end
          DISCARD: begin
            if (in_eop) begin
              drop_inc = 2'd1;
              wr_ptr_n = commit_ptr;
              state_n  = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      rem        <= '0;
      csum       <= '0;
      sop_flag   <= 1'b1;
      good_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      rem        <= rem_n;
      csum       <= csum_n;
      if (rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sop_flag <= out_eop;
      end
      if (good_inc && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // payload store, no reset needed: reads are gated by commit_ptr
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[AW-1:0]] <= {rem == 8'd1, in_data};
  end
endmodule

// File: tb/tb_switch_tx_receiver.sv
// Directed bench for switch_tx_receiver with PORT_ID=2, DEPTH=64, MAX_PAYLOAD=32.
module tb_switch_tx_receiver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid, out_ready = 1'b0, out_sop, out_eop;
  logic [7:0]  out_data;
  logic [15:0] good_cnt, drop_cnt;
  int          total = 0, bad = 0;
  logic [7:0]  cs;

  switch_tx_receiver #(.PORT_ID(8'd2), .DEPTH(64), .MAX_PAYLOAD(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    logic done = 1'b0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!done) check("send_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic recv(input string tag, input logic [7:0] d, input logic s, input logic e);
    logic done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (out_valid) begin
        check({tag, "_data"}, {24'b0, out_data}, {24'b0, d});
        check({tag, "_sopeop"}, {30'b0, out_sop, out_eop}, {30'b0, s, e});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) check({tag, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  task automatic send_cell(input logic [7:0] len, input logic [7:0] base);
    logic [7:0] c;
    send(8'h02, 1'b1, 1'b0);
    send(len, 1'b0, 1'b0);
    c = 8'h02 ^ len;
    for (int i = 0; i < int'(len); i++) begin
      send(base + 8'(i), 1'b0, 1'b0);
      c = c ^ (base + 8'(i));
    end
    send(c, 1'b0, 1'b1);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_good", {16'b0, good_cnt}, 32'd0);
    check("rst_drop", {16'b0, drop_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // basic good cell, csum = 02^03^11^22^33 = 01
    send(8'h02, 1, 0); send(8'h03, 0, 0); send(8'h11, 0, 0);
    send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h01, 0, 1);
    check("good_latency", {31'b0, out_valid}, 32'd1);
    recv("g1_0", 8'h11, 1, 0);
    recv("g1_1", 8'h22, 0, 0);
    recv("g1_2", 8'h33, 0, 1);
    #1 check("g1_empty", {31'b0, out_valid}, 32'd0);
    check("g1_good", {16'b0, good_cnt}, 32'd1);

    // same cell, bad csum
    send(8'h02, 1, 0); send(8'h03, 0, 0); send(8'h11, 0, 0);
    send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h00, 0, 1);
    check("bad_cs_valid", {31'b0, out_valid}, 32'd0);
    check("bad_cs_drop", {16'b0, drop_cnt}, 32'd1);
    check("bad_cs_wrptr", 32'(dut.wr_ptr), 32'd3);

    // wrong dest
    send(8'h05, 1, 0); send(8'h03, 0, 0); send(8'haa, 0, 0);
    send(8'hbb, 0, 0); send(8'hcc, 0, 0); send(8'h5b, 0, 1);
    check("dest_valid", {31'b0, out_valid}, 32'd0);
    check("dest_drop", {16'b0, drop_cnt}, 32'd2);

    // sop mid-payload, then a good cell: csum = 02^03^44^55^66 = 76
    send(8'h02, 1, 0); send(8'h03, 0, 0); send(8'h11, 0, 0);
    send(8'h02, 1, 0); send(8'h03, 0, 0); send(8'h44, 0, 0);
    send(8'h55, 0, 0); send(8'h66, 0, 0); send(8'h76, 0, 1);
    check("abort_drop", {16'b0, drop_cnt}, 32'd3);
    check("abort_good", {16'b0, good_cnt}, 32'd2);
    recv("ab_0", 8'h44, 1, 0);
    recv("ab_1", 8'h55, 0, 0);
    recv("ab_2", 8'h66, 0, 1);

    // fill the buffer with two 32-byte cells while downstream stalls
    send_cell(8'd32, 8'h40);
    send(8'h02, 1, 0); send(8'd32, 0, 0);
    cs = 8'h02 ^ 8'd32;
    for (int i = 0; i < 32; i++) begin
      send(8'h80 + 8'(i), 0, 0);
      cs = cs ^ (8'h80 + 8'(i));
    end
    @(negedge clk);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_good", {16'b0, good_cnt}, 32'd3);
    fork
      send(cs, 0, 1);
      begin
        for (int i = 0; i < 32; i++) recv("fa", 8'h40 + 8'(i), i == 0, i == 31);
        for (int i = 0; i < 32; i++) recv("fb", 8'h80 + 8'(i), i == 0, i == 31);
      end
    join
    check("fill_good", {16'b0, good_cnt}, 32'd4);
    #1 check("fill_empty", {31'b0, out_valid}, 32'd0);

    // length 0, length 33, single sop&eop byte
    send(8'h02, 1, 0); send(8'h00, 0, 0); send(8'hff, 0, 1);
    check("len0_drop", {16'b0, drop_cnt}, 32'd4);
    send(8'h02, 1, 0); send(8'h21, 0, 0); send(8'h00, 0, 1);
    check("len33_drop", {16'b0, drop_cnt}, 32'd5);
    send(8'h02, 1, 1);
    check("sopeop_drop", {16'b0, drop_cnt}, 32'd6);
    check("drops_no_out", {31'b0, out_valid}, 32'd0);
    check("drops_good", {16'b0, good_cnt}, 32'd4);

    // async reset mid-payload
    send(8'h02, 1, 0); send(8'h03, 0, 0); send(8'h11, 0, 0);
    rst = 1'b0;
    #1;
    check("mrst_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_good", {16'b0, good_cnt}, 32'd0);
    check("mrst_drop", {16'b0, drop_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send(8'h02, 1, 0); send(8'h03, 0, 0); send(8'h11, 0, 0);
    send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h01, 0, 1);
    recv("pr_0", 8'h11, 1, 0);
    recv("pr_1", 8'h22, 0, 0);
    recv("pr_2", 8'h33, 0, 1);
    check("pr_good", {16'b0, good_cnt}, 32'd1);
    check("pr_drop", {16'b0, drop_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
